// File: rtl/wb_pkg.sv
// Shared types for the GPR writeback writer: write modes, queue entry, byte alignment.
package wb_pkg;

  localparam int NGPR = 8;
  localparam int AW   = $clog2(NGPR);
  localparam int DW   = 16;

  typedef enum logic [1:0] {
    WM_NONE = 2'b00,
    WM_LO   = 2'b01,
    WM_HI   = 2'b10,
    WM_FULL = 2'b11
  } wmode_t;

  typedef struct packed {
    logic [AW-1:0] dest;
    logic [DW-1:0] data;
    wmode_t        mode;
  } wb_entry_t;

  // Byte results arrive in the low byte; the high lane is written from data[15:8].
  function automatic logic [DW-1:0] align_data(wmode_t m, logic [DW-1:0] x);
    case (m)
      WM_FULL: return x;
      WM_LO:   return {8'h00, x[7:0]};
      WM_HI:   return {x[7:0], 8'h00};
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Two-entry synchronous FIFO of writeback entries; exposes head and tail for hazard compares.
import wb_pkg::*;

module wb_fifo #(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  wb_entry_t push_dat_i,
  input  logic      pop_i,
  output logic      full_o,
  output logic      empty_o,
  output wb_entry_t head_o,
  output logic      head_vld_o,
  output wb_entry_t tail_o,
  output logic      tail_vld_o
);

  wb_entry_t  mem_q [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] cnt_q, cnt_d;
  logic       push_ok, pop_ok;

  assign full_o  = (cnt_q == 2'(DEPTH));
  assign empty_o = (cnt_q == 2'd0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push_ok;
    rd_ptr_d = rd_ptr_q ^ pop_ok;
    cnt_d    = cnt_q + {1'b0, push_ok} - {1'b0, pop_ok};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  // Tail is only meaningful when both slots hold entries.
  assign head_o     = mem_q[rd_ptr_q];
  assign head_vld_o = !empty_o;
  assign tail_o     = mem_q[~rd_ptr_q];
  assign tail_vld_o = (cnt_q == 2'd2);

endmodule

// File: rtl/wb_writer.sv
// Writeback writer: queues MEM/WB results, issues one GPR write per cycle, exports pending-write scoreboard.
// Optional forwarding of pending full-width results is enabled with WB_FWD_EN.
import wb_pkg::*;

module wb_writer #(
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_dest,
  input  logic [DW-1:0] in_data,
  input  logic [1:0]    in_mode,
  input  logic          hold,
  output logic [AW-1:0] d,
  output logic [DW-1:0] wr,
  output logic [1:0]    w_en,
  input  logic [AW-1:0] q0,
  input  logic [AW-1:0] q1,
  output logic          busy0,
  output logic          busy1
`ifdef WB_FWD_EN
  ,
  output logic          fwd0_valid,
  output logic [DW-1:0] fwd0_data,
  output logic          fwd1_valid,
  output logic [DW-1:0] fwd1_data
`endif
);

  wb_entry_t in_ent, head, tail, out_q, out_d;
  logic      full, empty, head_vld, tail_vld, push, pop, out_vld;

  assign in_ready = !full;
  assign push     = in_valid && in_ready && (wmode_t'(in_mode) != WM_NONE);
  assign pop      = !hold && !empty;

  always_comb begin
    in_ent.dest = in_dest;
    in_ent.mode = wmode_t'(in_mode);
    in_ent.data = align_data(wmode_t'(in_mode), in_data);
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_dat_i (in_ent),
    .pop_i      (pop),
    .full_o     (full),
    .empty_o    (empty),
    .head_o     (head),
    .head_vld_o (head_vld),
    .tail_o     (tail),
    .tail_vld_o (tail_vld)
  );

  // Output register loads an idle write whenever nothing drains, so a write never repeats.
  always_comb begin
    out_d = '0;
    if (pop) out_d = head;
  end

  always_ff @(posedge clk) begin
    if (rst) out_q <= '0;
    else     out_q <= out_d;
  end

  assign d       = out_q.dest;
  assign wr      = out_q.data;
  assign w_en    = out_q.mode;
  assign out_vld = (out_q.mode != WM_NONE);

  function automatic logic pending(logic [AW-1:0] q, logic ov, wb_entry_t o,
                                   logic hv, wb_entry_t h, logic tv, wb_entry_t t);
    return (ov && o.dest == q) || (hv && h.dest == q) || (tv && t.dest == q);
  endfunction

  assign busy0 = pending(q0, out_vld, out_q, head_vld, head, tail_vld, tail);
  assign busy1 = pending(q1, out_vld, out_q, head_vld, head, tail_vld, tail);

`ifdef WB_FWD_EN
  // Later checks override earlier ones: tail is newest, then head, then output register.
  function automatic logic [DW:0] fwd_pick(logic [AW-1:0] q, logic ov, wb_entry_t o,
                                           logic hv, wb_entry_t h, logic tv, wb_entry_t t);
    wb_entry_t sel;
    logic      hit;
    sel = '0;
    hit = 1'b0;
    if (ov && o.dest == q) begin hit = 1'b1; sel = o; end
    if (hv && h.dest == q) begin hit = 1'b1; sel = h; end
    if (tv && t.dest == q) begin hit = 1'b1; sel = t; end
    if (hit && sel.mode == WM_FULL) return {1'b1, sel.data};
    return '0;
  endfunction

  assign {fwd0_valid, fwd0_data} = fwd_pick(q0, out_vld, out_q, head_vld, head, tail_vld, tail);
  assign {fwd1_valid, fwd1_data} = fwd_pick(q1, out_vld, out_q, head_vld, head, tail_vld, tail);
`endif

endmodule
